// File: rtl/nibble_serial_adder_if.sv
// Request/result and external adder signals for nibble_serial_adder.
// slave = the controller, master = its environment (requester plus adder).
interface nibble_serial_adder_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic         Sub;
    logic         CinIn;
    logic [W-1:0] OpA;
    logic [W-1:0] OpB;
    logic [3:0]   AddA;
    logic [3:0]   AddB;
    logic         AddCin;
    logic [3:0]   AddSum;
    logic         AddCout;
    logic         busy;
    logic         done;
    logic [W-1:0] Result;
    logic         CoutOut;
    logic         Ovf;

    modport slave (
        input  start, Sub, CinIn, OpA, OpB, AddSum, AddCout,
        output AddA, AddB, AddCin, busy, done, Result, CoutOut, Ovf
    );

    modport master (
        output start, Sub, CinIn, OpA, OpB, AddSum, AddCout,
        input  AddA, AddB, AddCin, busy, done, Result, CoutOut, Ovf
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// Wide add/subtract through one external 4-bit adder, one nibble per clock,
// LSB first, with the carry chained through an internal register.
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    nibble_serial_adder_if.slave bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic          carry;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [W-1:0]  a_sh;
    logic [W-1:0]  b_sh;

    // Adder is fed only while a nibble is in flight; quiet otherwise.
    always_comb begin
        a_sh       = a_reg >> {idx, 2'b00};
        b_sh       = b_reg >> {idx, 2'b00};
        bus.AddA   = 4'h0;
        bus.AddB   = 4'h0;
        bus.AddCin = 1'b0;
        if (state == RUN) begin
            bus.AddA   = a_sh[3:0];
            bus.AddB   = b_sh[3:0];
            bus.AddCin = carry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            carry       <= 1'b0;
            a_reg       <= '0;
            b_reg       <= '0;
            bus.Result  <= '0;
            bus.CoutOut <= 1'b0;
            bus.Ovf     <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_reg    <= bus.OpA;
                        b_reg    <= bus.Sub ? ~bus.OpB : bus.OpB;
                        carry    <= bus.Sub ? 1'b1 : bus.CinIn;
                        idx      <= '0;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    bus.Result[{idx, 2'b00} +: 4] <= bus.AddSum;
                    carry <= bus.AddCout;
                    if (idx == LAST) begin
                        bus.CoutOut <= bus.AddCout;
                        // b_reg holds the operand actually added, so this also covers Sub.
                        bus.Ovf  <= (a_reg[W-1] == b_reg[W-1]) &&
                                    (bus.AddSum[3] != a_reg[W-1]);
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
